packed_ram_sdp: RTL

Parametrised simple-dual-port synchronous RAM. It is the successor to the team's single-port tristate packed-array memory and has:
- separate write and read ports, with no bidirectional bus;
- byte-lane write enables;
- a configurable registered read latency with a valid strobe;
- a selectable read-during-write policy;
- an optional hardware clear sweep after reset.

It is used as the on-chip weight and activation buffer between the DMA loader and the compute datapath.

---
 rtl/packed_ram_pkg.sv | 18 +
 rtl/packed_ram_rd_pipe.sv | 39 +++
 rtl/packed_ram_sdp.sv | 109 ++++++++++
 3 files changed

// File: rtl/packed_ram_pkg.sv
// Shared types and helpers for the packed simple-dual-port RAM.
package packed_ram_pkg;

    typedef enum logic {
        READ_FIRST  = 1'b0,
        WRITE_FIRST = 1'b1
    } rdw_mode_e;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_e;

    function automatic int be_width(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/packed_ram_rd_pipe.sv
// Valid/data delay line for the read path; data registers load only on valid
// beats so the final stage holds the last returned word.
module packed_ram_rd_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int STAGES     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [STAGES-1:0]                 vld_q;
    logic [STAGES-1:0][DATA_WIDTH-1:0] dat_q;
    logic [STAGES:0]                   vld_pipe;
    logic [STAGES:0][DATA_WIDTH-1:0]   dat_pipe;

    // Index 0 is the unregistered input; index s+1 is register s.
    assign vld_pipe = {vld_q, in_valid};
    assign dat_pipe = {dat_q, in_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_pipe[STAGES-1:0];
            for (int s = 0; s < STAGES; s++) begin
                if (vld_pipe[s]) dat_q[s] <= dat_pipe[s];
            end
        end
    end

    assign out_valid = vld_pipe[STAGES];
    assign out_data  = dat_pipe[STAGES];

endmodule

// File: rtl/packed_ram_sdp.sv
// Simple-dual-port RAM with byte enables, registered read latency,
// selectable read-during-write policy and an optional post-reset clear sweep.
module packed_ram_sdp
    import packed_ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 10,
    parameter int BYTE_WIDTH     = 8,
    parameter int RD_LATENCY     = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    output logic                                          init_done,
    input  logic                                          wr_en,
    input  logic [ADDR_WIDTH-1:0]                         wr_addr,
    input  logic [DATA_WIDTH-1:0]                         wr_data,
    input  logic [be_width(DATA_WIDTH, BYTE_WIDTH)-1:0]   wr_be,
    input  logic                                          rd_en,
    input  logic [ADDR_WIDTH-1:0]                         rd_addr,
    output logic [DATA_WIDTH-1:0]                         rd_data,
    output logic                                          rd_valid
);

    localparam int                    NUM_BE    = be_width(DATA_WIDTH, BYTE_WIDTH);
    localparam int                    DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam bit                    WR_FIRST  = (RDW_MODE == int'(WRITE_FIRST));

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("packed_ram_sdp: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_latency
        $error("packed_ram_sdp: RD_LATENCY must be in 1..3");
    end

    ram_state_e              state;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic                    wr_fire;
    logic                    rd_fire;
    logic [DATA_WIDTH-1:0]   be_mask;
    logic [DATA_WIDTH-1:0]   old_word;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            init_done <= (CLEAR_ON_RESET == 0);
            clr_cnt   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST_ADDR) begin
                        state     <= READY;
                        init_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Traffic is only honoured once the sweep has finished.
    assign wr_fire = wr_en && (state == READY);
    assign rd_fire = rd_en && (state == READY);

    always_comb begin
        be_mask = '0;
        for (int i = 0; i < NUM_BE; i++) begin
            be_mask[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{wr_be[i]}};
        end
    end

    assign old_word = mem[rd_addr];

    // Write-first bypass forwards the merged word of a same-cycle write.
    always_comb begin
        rd_word = old_word;
        if (WR_FIRST && wr_fire && (wr_addr == rd_addr)) begin
            rd_word = (old_word & ~be_mask) | (wr_data & be_mask);
        end
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < NUM_BE; i++) begin
                if (wr_be[i]) mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    packed_ram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .STAGES     (RD_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_fire),
        .in_data   (rd_word),
        .out_valid (rd_valid),
        .out_data  (rd_data)
    );

endmodule
